mem_bus_initiator: RTL

//  Bus master that converts single UM core memory commands into cycle-accurate
//  mem_in_bus_t transactions for the memory system, and returns results.

---
 rtl/mem_bus_initiator.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_initiator.sv
// Bus master turning single UM core memory commands (LOAD/STORE/ALLOC/SETPROG/FREE)
// into registered one-cycle beats on the shared memory bus, with a one-cycle response pulse.
package mem_bus_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] offset;
    logic [31:0] data;
    logic [1:0]  mode;
  } mem_in_bus_t;
endpackage

module mem_bus_initiator #(
  parameter logic [31:0] MAX_ALLOC_WORDS = 32'h0100_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_offset,
  input  logic [31:0]              req_data,
  output logic                     resp_valid,
  output logic [31:0]              resp_data,
  output logic                     resp_err,
  output mem_bus_pkg::mem_in_bus_t mem_bus,
  output logic                     mem_bus_en,
  input  logic [31:0]              mem_data_out
);
  import mem_bus_pkg::*;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR       = 3'd3,
    AL_ISSUE = 3'd4,
    AL_WAIT  = 3'd5,
    AL_FILL  = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_STORE   = 3'b001;
  localparam logic [2:0] OP_ALLOC   = 3'b010;
  localparam logic [2:0] OP_SETPROG = 3'b011;
  localparam logic [2:0] OP_FREE    = 3'b100;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;
  logic        resp_valid_q, resp_valid_d;
  logic        req_ready_q, req_ready_d;
  mem_in_bus_t mem_bus_q, mem_bus_d;
  logic        mem_bus_en_q, mem_bus_en_d;
  logic [31:0] alloc_n_s;

  // Next-state, response and next-beat computation; beats are computed one cycle ahead so they leave a flop.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    mem_bus_d    = '{addr: 32'd0, offset: 32'd0, data: 32'd0, mode: 2'b00};
    mem_bus_en_d = 1'b0;
    // Zero-length ALLOC still reserves one word so two such allocations never share an id.
    alloc_n_s    = (req_offset == 32'd0) ? 32'd1 : req_offset;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          resp_data_d = 32'd0;
          resp_err_d  = 1'b0;
          case (req_op)
            OP_LOAD: begin
              state_d      = RD_ISSUE;
              mem_bus_d    = '{addr: req_addr, offset: req_offset, data: 32'd0, mode: 2'b00};
              mem_bus_en_d = 1'b1;
            end
            OP_STORE: begin
              state_d      = WR;
              mem_bus_d    = '{addr: req_addr, offset: req_offset, data: req_data, mode: 2'b01};
              mem_bus_en_d = 1'b1;
            end
            OP_SETPROG: begin
              state_d      = WR;
              mem_bus_d    = '{addr: 32'd0, offset: 32'd0, data: req_data, mode: 2'b11};
              mem_bus_en_d = 1'b1;
            end
            OP_ALLOC: begin
              if (alloc_n_s > MAX_ALLOC_WORDS) begin
                state_d    = DONE;
                resp_err_d = 1'b1;
              end else begin
                state_d      = AL_ISSUE;
                len_d        = alloc_n_s;
                mem_bus_d    = '{addr: 32'd0, offset: alloc_n_s, data: 32'd0, mode: 2'b10};
                mem_bus_en_d = 1'b1;
              end
            end
            OP_FREE: begin
              state_d = DONE;
            end
            default: begin
              state_d    = DONE;
              resp_err_d = 1'b1;
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        state_d     = DONE;
        resp_data_d = mem_data_out;
      end
      WR:       state_d = DONE;
      AL_ISSUE: state_d = AL_WAIT;
      AL_WAIT: begin
        state_d      = AL_FILL;
        base_d       = mem_data_out;
        cnt_d        = 32'd0;
        mem_bus_d    = '{addr: mem_data_out, offset: 32'd0, data: 32'd0, mode: 2'b01};
        mem_bus_en_d = 1'b1;
      end
      AL_FILL: begin
        if (cnt_q == len_q - 32'd1) begin
          state_d     = DONE;
          resp_data_d = base_q;
        end else begin
          cnt_d        = cnt_q + 32'd1;
          mem_bus_d    = '{addr: base_q, offset: cnt_q + 32'd1, data: 32'd0, mode: 2'b01};
          mem_bus_en_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
  end

  // State, latched request length/base, fill counter and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      len_q        <= 32'd0;
      base_q       <= 32'd0;
      cnt_q        <= 32'd0;
      resp_data_q  <= 32'd0;
      resp_err_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_bus_q    <= '{addr: 32'd0, offset: 32'd0, data: 32'd0, mode: 2'b00};
      mem_bus_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      mem_bus_q    <= mem_bus_d;
      mem_bus_en_q <= mem_bus_en_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_bus    = mem_bus_q;
  assign mem_bus_en = mem_bus_en_q;

endmodule
